// File: rtl/div_clk_pkg.sv
// Shared types and defaults for the divided-clock producer/consumer pair.
package div_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    TRACK = 2'd2,
    LOCK  = 2'd3
  } monitor_state_t;

  // Must track the divider's divide ratio and the consumer synchroniser depth.
  localparam int DEF_EXPECTED_PERIOD = 3;
  localparam int DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for a slow clock plus a registered rising-edge detector.
module sync_edge_detect
  import div_clk_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clkin,
  input  logic reset,
  input  logic hold,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_out;
  logic                   prev_q;
  logic                   prev_d;
  logic                   rise_q;
  logic                   rise_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // hold keeps prev at 0 so a level already high is seen as a fresh edge on release
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    if (hold) begin
      prev_d = 1'b0;
    end else begin
      prev_d = sync_out;
    end
    rise_d = sync_out & ~prev_q;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/div_clock_monitor.sv
// Fast-domain monitor for a divided clock: edge enable, period measurement,
// lock tracking and saturating error statistics.
module div_clock_monitor
  import div_clk_pkg::*;
#(
  parameter int EXPECTED_PERIOD = DEF_EXPECTED_PERIOD,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = 4,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int CW              = 8,
  parameter int ECW             = 8
) (
  input  logic           clkin,
  input  logic           reset,
  input  logic           div_clk_in,
  input  logic           enable,
  input  logic           err_clr,
  output logic           edge_pulse,
  output logic [CW-1:0]  period,
  output logic           period_valid,
  output logic           locked,
  output logic           err,
  output logic [ECW-1:0] err_count
);

  localparam int          LO_I   = EXPECTED_PERIOD - TOLERANCE;
  localparam int          LO     = (LO_I < 0) ? 0 : LO_I;
  localparam int          HI     = EXPECTED_PERIOD + TOLERANCE;
  localparam logic [CW:0] LO_B   = (CW+1)'(LO);
  localparam logic [CW:0] HI_B   = (CW+1)'(HI);
  localparam int          GW     = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_COUNT);

  monitor_state_t state_q;
  monitor_state_t state_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [GW-1:0]  good_cnt_q;
  logic [GW-1:0]  good_cnt_d;
  logic [GW-1:0]  good_inc;
  logic           rise;
  logic           hold_idle;
  logic [CW:0]    meas_ext;
  logic [CW-1:0]  period_meas;
  logic           good;
  logic           timeout;
  logic           err_evt;
  logic           upd;

  logic           edge_pulse_q;
  logic           edge_pulse_d;
  logic [CW-1:0]  period_q;
  logic [CW-1:0]  period_d;
  logic           period_valid_q;
  logic           period_valid_d;
  logic           locked_q;
  logic           locked_d;
  logic           err_q;
  logic           err_d;
  logic [ECW-1:0] err_count_q;
  logic [ECW-1:0] err_count_d;

  assign hold_idle = (state_q == IDLE);

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clkin (clkin),
    .reset (reset),
    .hold  (hold_idle),
    .d     (div_clk_in),
    .rise  (rise)
  );

  // Period is cnt+1 because cnt restarts at 0 the cycle after a rise.
  always_comb begin
    meas_ext    = {1'b0, cnt_q} + (CW+1)'(1);
    period_meas = meas_ext[CW] ? {CW{1'b1}} : meas_ext[CW-1:0];
    good        = ({1'b0, period_meas} >= LO_B) && ({1'b0, period_meas} <= HI_B);
    timeout     = ({1'b0, cnt_q} == HI_B) && !rise;
    good_inc    = good_cnt_q + GW'(1);
  end

  always_comb begin
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = '0;
    end else if (cnt_q == {CW{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_evt    = 1'b0;
    upd        = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = SEEK;
        good_cnt_d = '0;
      end
      SEEK: begin
        if (rise) begin
          state_d = TRACK;
        end else begin
          state_d = SEEK;
        end
      end
      TRACK: begin
        if (rise) begin
          upd = 1'b1;
          if (!good) begin
            good_cnt_d = '0;
          end else if (good_inc == LOCK_N) begin
            state_d    = LOCK;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end else begin
          good_cnt_d = good_cnt_q;
        end
      end
      LOCK: begin
        upd = rise;
        // A missing edge trips the timeout once; leaving LOCK stops it repeating.
        if ((rise && !good) || timeout) begin
          err_evt    = 1'b1;
          state_d    = TRACK;
          good_cnt_d = '0;
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d    = IDLE;
        good_cnt_d = '0;
      end
    endcase
    if (!enable) begin
      state_d    = IDLE;
      good_cnt_d = '0;
      err_evt    = 1'b0;
      upd        = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  always_comb begin
    edge_pulse_d   = rise && enable && (state_q != IDLE);
    period_valid_d = upd;
    period_d       = upd ? period_meas : period_q;
    locked_d       = (state_d == LOCK);
    err_d          = err_evt;
    if (err_clr) begin
      err_count_d = err_evt ? ECW'(1) : '0;
    end else if (err_evt && (err_count_q != {ECW{1'b1}})) begin
      err_count_d = err_count_q + ECW'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      good_cnt_q     <= '0;
      edge_pulse_q   <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_cnt_q     <= good_cnt_d;
      edge_pulse_q   <= edge_pulse_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_q          <= err_d;
      err_count_q    <= err_count_d;
    end
  end

  assign edge_pulse   = edge_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_div_clock_monitor.sv
// Bench for div_clock_monitor: table-driven start-up, directed corner sequences
// and randomized div_clk_in patterns checked against a timestamp-based model.
module tb_div_clock_monitor;

  localparam int EP  = 3;
  localparam int TOL = 0;
  localparam int LC  = 4;
  localparam int SS  = 2;
  localparam int LOB = (EP - TOL < 0) ? 0 : EP - TOL;
  localparam int HIB = EP + TOL;

  localparam int M_IDLE  = 0;
  localparam int M_SEEK  = 1;
  localparam int M_TRACK = 2;
  localparam int M_LOCK  = 3;

  logic       clkin = 1'b0;
  logic       reset;
  logic       div_clk_in;
  logic       enable;
  logic       err_clr;
  logic       edge_pulse;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: sampled-input history, rise timestamps, expected outputs
  logic hq[$];
  logic m_prev;
  logic m_rise;
  int   m_state;
  int   m_cyc;
  int   m_last;
  int   m_good;
  logic       e_ep;
  logic       e_pv;
  logic       e_lock;
  logic       e_err;
  logic [7:0] e_period;
  logic [7:0] e_errcnt;

  // stimulus helpers
  logic force_clr   = 1'b0;
  logic clr_on_err  = 1'b0;
  int   clr_pct     = 0;
  int   step_idx    = 0;
  int   first_ep    = -1;
  logic first_ep_pv = 1'b0;
  int   pv_log[$];

  typedef struct {
    logic       d;
    logic       ep;
    logic       pv;
    logic       lk;
    logic [7:0] per;
  } vec_t;
  vec_t tbl[18];

  div_clock_monitor dut (
    .clkin       (clkin),
    .reset       (reset),
    .div_clk_in  (div_clk_in),
    .enable      (enable),
    .err_clr     (err_clr),
    .edge_pulse  (edge_pulse),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    m_prev   = 1'b0;
    m_rise   = 1'b0;
    m_state  = M_IDLE;
    m_cyc    = 0;
    m_last   = 0;
    m_good   = 0;
    e_ep     = 1'b0;
    e_pv     = 1'b0;
    e_lock   = 1'b0;
    e_err    = 1'b0;
    e_period = 8'd0;
    e_errcnt = 8'd0;
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic m_err_now(input logic e);
    int  per;
    int  cnt;
    logic good;
    per  = sat255(m_cyc - m_last);
    cnt  = sat255(m_cyc - m_last - 1);
    good = (per >= LOB) && (per <= HIB);
    return e && (m_state == M_LOCK) && ((m_rise && !good) || (!m_rise && cnt == HIB));
  endfunction

  // Advance the model across one clock edge with the inputs presented before it.
  task automatic model_step(input logic d, input logic e, input logic c);
    int   per;
    int   nxt;
    logic errv;
    logic pv;
    logic so;
    logic good;
    per  = sat255(m_cyc - m_last);
    good = (per >= LOB) && (per <= HIB);
    errv = m_err_now(e);
    nxt  = m_state;
    pv   = 1'b0;
    if (!e) begin
      nxt    = M_IDLE;
      m_good = 0;
    end else if (m_state == M_IDLE) begin
      nxt    = M_SEEK;
      m_good = 0;
    end else if (m_state == M_SEEK) begin
      if (m_rise) nxt = M_TRACK;
    end else if (m_state == M_TRACK) begin
      if (m_rise) begin
        pv = 1'b1;
        if (good) begin
          m_good++;
          if (m_good == LC) begin
            nxt    = M_LOCK;
            m_good = 0;
          end
        end else begin
          m_good = 0;
        end
      end
    end else begin
      pv = m_rise;
      if (errv) begin
        nxt    = M_TRACK;
        m_good = 0;
      end
    end
    e_ep   = m_rise && e && (m_state != M_IDLE);
    e_pv   = pv;
    if (pv) e_period = 8'(per);
    e_lock = (nxt == M_LOCK);
    e_err  = errv;
    if (c) e_errcnt = errv ? 8'd1 : 8'd0;
    else if (errv && e_errcnt != 8'd255) e_errcnt = e_errcnt + 8'd1;
    if (m_rise && m_state != M_IDLE) m_last = m_cyc;
    so     = (hq.size() >= SS) ? hq[SS-1] : 1'b0;
    m_rise = so && !m_prev;
    m_prev = (m_state == M_IDLE) ? 1'b0 : so;
    hq.push_front(d);
    if (hq.size() > SS) hq.pop_back();
    m_state = nxt;
    m_cyc++;
  endtask

  task automatic check_all();
    n_total++;
    if (edge_pulse === e_ep && period_valid === e_pv && locked === e_lock &&
        err === e_err && period === e_period && err_count === e_errcnt) begin
      n_pass++;
    end else begin
      $display("FAIL model cyc%0d: got ep%b pv%b lk%b err%b per%0d cnt%0d, expected ep%b pv%b lk%b err%b per%0d cnt%0d",
               m_cyc, edge_pulse, period_valid, locked, err, period, err_count,
               e_ep, e_pv, e_lock, e_err, e_period, e_errcnt);
    end
  endtask

  task automatic step(input logic d, input logic e);
    logic c;
    c = force_clr || (clr_on_err && m_err_now(e)) ||
        ((clr_pct > 0) && ($urandom_range(0, 99) < clr_pct));
    force_clr  = 1'b0;
    div_clk_in = d;
    enable     = e;
    err_clr    = c;
    model_step(d, e, c);
    @(posedge clkin);
    #1;
    check_all();
    step_idx++;
    if (period_valid) pv_log.push_back(int'(period));
    if (edge_pulse && first_ep < 0) begin
      first_ep    = step_idx;
      first_ep_pv = period_valid;
    end
  endtask

  task automatic pat(input int hi, input int lo, input int cnt, input logic e);
    for (int p = 0; p < cnt; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1, e);
      for (int i = 0; i < lo; i++) step(1'b0, e);
    end
  endtask

  function automatic logic seen(input int v);
    foreach (pv_log[i]) if (pv_log[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    for (int k = 1; k <= 18; k++) begin
      tbl[k-1].d   = ((k - 1) % 3 == 0);
      tbl[k-1].ep  = (k >= 4) && ((k - 1) % 3 == 0);
      tbl[k-1].pv  = (k >= 7) && ((k - 1) % 3 == 0);
      tbl[k-1].per = (k >= 7) ? 8'd3 : 8'd0;
      tbl[k-1].lk  = (k >= 16);
    end

    reset      = 1'b1;
    div_clk_in = 1'b0;
    enable     = 1'b0;
    err_clr    = 1'b0;
    repeat (3) @(posedge clkin);
    #1;
    chk("reset_state", {edge_pulse, period_valid, locked, err, period, err_count}, 0);
    reset = 1'b0;
    model_reset();
    chk("release_state", {edge_pulse, period_valid, locked, err, period, err_count}, 0);

    // start-up: 1 high / 2 low, enable from the first edge
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].d, 1'b1);
      n_total++;
      if (edge_pulse === tbl[i].ep && period_valid === tbl[i].pv && locked === tbl[i].lk &&
          period === tbl[i].per && err === 1'b0) begin
        n_pass++;
      end else begin
        $display("FAIL table row %0d: got ep%b pv%b lk%b per%0d err%b, expected ep%b pv%b lk%b per%0d err0",
                 i, edge_pulse, period_valid, locked, period, err,
                 tbl[i].ep, tbl[i].pv, tbl[i].lk, tbl[i].per);
      end
    end

    // stretched low phase while locked
    pv_log.delete();
    pat(1, 3, 1, 1'b1);
    pat(1, 2, 7, 1'b1);
    chk("stretch_errcnt", err_count, 1);
    chk("stretch_period4_seen", seen(4), 1);
    chk("stretch_relock", locked, 1);

    // short period while locked
    pv_log.delete();
    pat(1, 1, 1, 1'b1);
    pat(1, 2, 7, 1'b1);
    chk("short_errcnt", err_count, 2);
    chk("short_period2_seen", seen(2), 1);
    chk("short_relock", locked, 1);

    // missing edge: timeout then a bad period measured in TRACK
    pat(1, 5, 1, 1'b1);
    pat(1, 2, 7, 1'b1);
    chk("timeout_errcnt", err_count, 3);
    chk("timeout_relock", locked, 1);

    // enable dropped while locked
    step(1'b1, 1'b0);
    chk("disable_locked", locked, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    pat(1, 2, 2, 1'b0);
    chk("disable_period_hold", period, 3);
    chk("disable_errcnt_hold", err_count, 3);
    pat(1, 2, 8, 1'b1);
    chk("reenable_lock", locked, 1);

    // very long gap saturates the measured period
    pv_log.delete();
    pat(1, 300, 1, 1'b1);
    pat(1, 2, 7, 1'b1);
    chk("gap_period255_seen", seen(255), 1);
    chk("gap_errcnt", err_count, 4);

    // err_count saturation and clear interactions
    force_clr = 1'b1;
    pat(1, 2, 1, 1'b1);
    chk("clr_alone_zero", err_count, 0);
    for (int it = 0; it < 256; it++) begin
      pat(1, 1, 1, 1'b1);
      pat(1, 2, 4, 1'b1);
    end
    chk("errcnt_saturated", err_count, 255);
    pat(1, 2, 6, 1'b1);
    clr_on_err = 1'b1;
    pat(1, 1, 1, 1'b1);
    pat(1, 2, 2, 1'b1);
    clr_on_err = 1'b0;
    chk("clr_with_err_one", err_count, 1);
    force_clr = 1'b1;
    pat(1, 2, 1, 1'b1);
    chk("clr_alone_after", err_count, 0);

    // randomized patterns
    clr_pct = 3;
    for (int r = 0; r < 150; r++) begin
      int   hi;
      int   lo;
      logic e;
      if ($urandom_range(0, 1) == 0) begin
        hi = 1;
        lo = 2;
      end else begin
        hi = $urandom_range(1, 3);
        lo = $urandom_range(1, 4);
      end
      e = ($urandom_range(0, 19) != 0);
      pat(hi, lo, 1, e);
    end
    clr_pct = 0;

    // asynchronous reset between two edges while locked
    pat(1, 2, 8, 1'b1);
    chk("pre_reset_locked", locked, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {edge_pulse, period_valid, locked, err, period, err_count}, 0);
    @(posedge clkin);
    #1;
    reset = 1'b0;
    model_reset();
    step_idx = 0;
    first_ep = -1;
    pat(1, 2, 4, 1'b1);
    chk("post_reset_first_ep", first_ep, 4);
    chk("post_reset_first_pv", first_ep_pv, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
